// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer port bundle: instruction-memory request/response, the decode handshake
// and the redirect/halt controls from the PC logic.
interface fetch_sequencer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  oMemReq;
  logic [ADDR_WIDTH-1:0] oMemAddr;
  logic                  iMemValid;
  logic [DATA_WIDTH-1:0] iMemData;
  logic                  oInstrValid;
  logic [DATA_WIDTH-1:0] oInstr;
  logic [ADDR_WIDTH-1:0] oInstrPC;
  logic                  iInstrReady;
  logic                  iRedirect;
  logic [ADDR_WIDTH-1:0] iRedirectPC;
  logic                  iHalt;
  logic                  oMisaligned;

  // Decode handshake: oInstr/oInstrPC transfer on a rising clock edge where oInstrValid and
  // iInstrReady are both high; oInstrValid never waits on iInstrReady. oMemReq is a one-word
  // request with no back-pressure, answered by an in-order iMemValid pulse at least a cycle later.
  modport master (
    output oMemReq, oMemAddr, oInstrValid, oInstr, oInstrPC, oMisaligned,
    input  iMemValid, iMemData, iInstrReady, iRedirect, iRedirectPC, iHalt
  );

  modport slave (
    input  oMemReq, oMemAddr, oInstrValid, oInstr, oInstrPC, oMisaligned,
    output iMemValid, iMemData, iInstrReady, iRedirect, iRedirectPC, iHalt
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Credit-limited instruction fetch: issues word-aligned reads, buffers in-order responses
// with their PCs, and flushes buffered and in-flight fetches on a redirect.
module fetch_sequencer #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    DEPTH      = 4
) (
  input  logic               iClk,
  input  logic               iRstN,
  fetch_sequencer_if.master  bus,
  output logic [1:0]         oDbgState
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [PW-1:0]         r_out;
  logic [PW-1:0]         r_drop;
  logic [AW-1:0]         r_tag_wptr;
  logic [AW-1:0]         r_tag_rptr;
  logic                  r_misaligned;
  logic [DATA_WIDTH-1:0] r_buf_data [DEPTH];
  logic [ADDR_WIDTH-1:0] r_buf_pc   [DEPTH];
  logic [ADDR_WIDTH-1:0] r_tag      [DEPTH];

  logic          w_empty;
  logic          w_full;
  logic [PW-1:0] w_occ;
  logic          w_credit;
  logic          w_redirect;
  logic          w_issue;
  logic          w_enq;
  logic          w_deq;

  assign w_occ      = r_wptr - r_rptr;
  assign w_empty    = (r_wptr == r_rptr);
  assign w_full     = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[PW-1] != r_rptr[PW-1]);
  // Buffered plus in-flight words may not exceed the buffer, so every response has a slot.
  assign w_credit   = ({1'b0, w_occ} + {1'b0, r_out}) < (PW+1)'(DEPTH);
  assign w_redirect = bus.iRedirect && (r_state != ST_BOOT);
  assign w_issue    = (r_state == ST_RUN) && w_credit && !w_redirect;
  assign w_enq      = bus.iMemValid && (r_drop == '0) && !w_redirect;
  assign w_deq      = !w_empty && bus.iInstrReady && !w_redirect;

  assign bus.oMemReq     = w_issue;
  assign bus.oMemAddr    = w_issue ? r_pc : '0;
  assign bus.oInstrValid = !w_empty;
  assign bus.oInstr      = w_empty ? '0 : r_buf_data[r_rptr[AW-1:0]];
  assign bus.oInstrPC    = w_empty ? '0 : r_buf_pc[r_rptr[AW-1:0]];
  assign bus.oMisaligned = r_misaligned;
  assign oDbgState       = r_state;

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_state      <= ST_BOOT;
      r_pc         <= RESET_PC;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_out        <= '0;
      r_drop       <= '0;
      r_tag_wptr   <= '0;
      r_tag_rptr   <= '0;
      r_misaligned <= 1'b0;
    end else begin
      case (r_state)
        ST_BOOT:   r_state <= ST_RUN;
        ST_RUN:    if (bus.iHalt) r_state <= ST_HALTED;
        ST_HALTED: if (!bus.iHalt) r_state <= ST_RUN;
        default:   r_state <= ST_BOOT;
      endcase

      r_misaligned <= w_redirect && (bus.iRedirectPC[1:0] != 2'b00);

      if (w_redirect) r_pc <= {bus.iRedirectPC[ADDR_WIDTH-1:2], 2'b00};
      else if (w_issue) r_pc <= r_pc + ADDR_WIDTH'(4);

      r_out <= r_out + PW'(w_issue) - PW'(bus.iMemValid);

      // Everything still in flight after this cycle's response belongs to the old path.
      if (w_redirect) r_drop <= r_out - PW'(bus.iMemValid);
      else if (bus.iMemValid && (r_drop != '0)) r_drop <= r_drop - PW'(1);

      if (w_issue) r_tag_wptr <= r_tag_wptr + AW'(1);
      if (bus.iMemValid) r_tag_rptr <= r_tag_rptr + AW'(1);

      if (w_redirect) begin
        r_rptr <= r_wptr;
      end else begin
        if (w_enq) r_wptr <= r_wptr + PW'(1);
        if (w_deq) r_rptr <= r_rptr + PW'(1);
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (w_issue) r_tag[r_tag_wptr] <= r_pc;
    if (w_enq) begin
      r_buf_data[r_wptr[AW-1:0]] <= bus.iMemData;
      r_buf_pc[r_wptr[AW-1:0]]   <= r_tag[r_tag_rptr];
    end
  end

  a_no_overflow: assert property (@(posedge iClk) disable iff (!iRstN)
    !(bus.iMemValid && (r_drop == '0) && w_full && !w_redirect));
endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: in-order memory model with programmable latency, decode-side
// scoreboard of {pc, instr}, and per-scenario tasks.
module tb_fetch_sequencer;
  logic       clk;
  logic       rst_n;
  logic [1:0] dbg;
  logic [1:0] dbg2;

  int vectors     = 0;
  int miscompares = 0;
  int mem_lat     = 1;

  logic [63:0] exp_q[$];
  logic [31:0] mq_addr[$];
  int          mq_due[$];

  fetch_sequencer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
  fetch_sequencer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus2 ();

  fetch_sequencer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .iClk(clk), .iRstN(rst_n), .bus(bus), .oDbgState(dbg)
  );

  fetch_sequencer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dut2 (
    .iClk(clk), .iRstN(rst_n), .bus(bus2), .oDbgState(dbg2)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  // Memory model: request seen in cycle c is answered in cycle c + mem_lat.
  initial begin
    int cyc;
    cyc = 0;
    bus.iMemValid = 1'b0;
    bus.iMemData  = '0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (!rst_n) begin
        mq_addr.delete();
        mq_due.delete();
        bus.iMemValid = 1'b0;
        bus.iMemData  = '0;
      end else if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
        bus.iMemValid = 1'b1;
        bus.iMemData  = mem_word(mq_addr.pop_front());
        void'(mq_due.pop_front());
      end else begin
        bus.iMemValid = 1'b0;
        bus.iMemData  = '0;
      end
      @(negedge clk);
      if (rst_n && bus.oMemReq) begin
        mq_addr.push_back(bus.oMemAddr);
        mq_due.push_back(cyc + mem_lat);
      end
    end
  end

  // Scoreboard consumer: every accepted decode transfer must match the queue head.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.oInstrValid && bus.iInstrReady && !bus.iRedirect) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL sb_unexpected got pc=%h instr=%h, required no transfer", bus.oInstrPC, bus.oInstr);
        end else begin
          e = exp_q.pop_front();
          if ({bus.oInstrPC, bus.oInstr} !== e)
            begin
              miscompares++;
              $display("FAIL sb_instr got pc=%h instr=%h, required pc=%h instr=%h",
                       bus.oInstrPC, bus.oInstr, e[63:32], e[31:0]);
            end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  // Driver tasks
  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic set_idle();
    bus.iInstrReady = 1'b0;
    bus.iRedirect   = 1'b0;
    bus.iRedirectPC = '0;
    bus.iHalt       = 1'b0;
  endtask

  task automatic do_reset(input int lat);
    rst_n   = 1'b0;
    mem_lat = lat;
    set_idle();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic push_seq(input logic [31:0] start, input int n);
    logic [31:0] a;
    a = start;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({a, mem_word(a)});
      a = a + 32'd4;
    end
  endtask

  task automatic drain(input int budget, output int used);
    used = 0;
    while (exp_q.size() != 0 && used < budget) begin
      next_cycle();
      used++;
    end
  endtask

  task automatic first_req(input int budget, output logic found, output logic [31:0] addr);
    found = 1'b0;
    addr  = '0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (bus.oMemReq) begin
        found = 1'b1;
        addr  = bus.oMemAddr;
      end
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    mem_lat = 1;
    set_idle();
    exp_q.delete();
    @(negedge clk);
    vectors++;
    if ({bus.oMemReq, bus.oMemAddr, bus.oInstrValid, bus.oInstr, bus.oInstrPC, bus.oMisaligned, dbg} !== '0)
      begin
        miscompares++;
        $display("FAIL reset_outputs got req=%b addr=%h v=%b instr=%h pc=%h mis=%b st=%0d, required all 0",
                 bus.oMemReq, bus.oMemAddr, bus.oInstrValid, bus.oInstr, bus.oInstrPC, bus.oMisaligned, dbg);
      end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if ({bus.oMemReq, dbg} !== {1'b0, 2'd0}) begin
      miscompares++;
      $display("FAIL boot_cycle got req=%b st=%0d, required req=0 st=0", bus.oMemReq, dbg);
    end
    next_cycle();
    @(negedge clk);
    vectors++;
    if ({bus.oMemReq, bus.oMemAddr, dbg} !== {1'b1, 32'h0, 2'd1}) begin
      miscompares++;
      $display("FAIL first_req got req=%b addr=%h st=%0d, required req=1 addr=0 st=1",
               bus.oMemReq, bus.oMemAddr, dbg);
    end
  endtask

  task automatic test_stream();
    int used;
    do_reset(1);
    bus.iInstrReady = 1'b1;
    push_seq(32'h0, 12);
    drain(40, used);
    bus.iInstrReady = 1'b0;
    vectors++;
    if (exp_q.size() != 0 || used != 15) begin
      miscompares++;
      $display("FAIL stream_rate got left=%0d cycles=%0d, required left=0 cycles=15", exp_q.size(), used);
    end
  endtask

  task automatic test_backpressure();
    int          reqs;
    int          used;
    logic [31:0] last;
    logic        found;
    logic [31:0] addr;
    do_reset(1);
    reqs = 0;
    last = '0;
    repeat (10) begin
      @(negedge clk);
      if (bus.oMemReq) begin
        reqs++;
        last = bus.oMemAddr;
      end
    end
    vectors++;
    if (reqs != 4 || last !== 32'hC) begin
      miscompares++;
      $display("FAIL bp_requests got count=%0d last=%h, required count=4 last=0000000c", reqs, last);
    end
    next_cycle();
    @(negedge clk);
    vectors++;
    if ({bus.oMemReq, bus.oInstrValid, bus.oInstrPC} !== {1'b0, 1'b1, 32'h0}) begin
      miscompares++;
      $display("FAIL bp_full got req=%b v=%b pc=%h, required req=0 v=1 pc=0",
               bus.oMemReq, bus.oInstrValid, bus.oInstrPC);
    end
    next_cycle();
    push_seq(32'h0, 10);
    bus.iInstrReady = 1'b1;
    first_req(4, found, addr);
    vectors++;
    if (!found || addr !== 32'h10) begin
      miscompares++;
      $display("FAIL bp_resume got found=%b addr=%h, required found=1 addr=00000010", found, addr);
    end
    next_cycle();
    drain(40, used);
    bus.iInstrReady = 1'b0;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL bp_drain got left=%0d, required 0", exp_q.size());
    end
  endtask

  task automatic test_redirect_flush();
    int used;
    do_reset(3);
    bus.iInstrReady = 1'b1;
    repeat (3) next_cycle();
    bus.iRedirect   = 1'b1;
    bus.iRedirectPC = 32'h100;
    @(negedge clk);
    vectors++;
    if (bus.oMemReq !== 1'b0) begin
      miscompares++;
      $display("FAIL redir_no_issue got req=%b, required 0", bus.oMemReq);
    end
    next_cycle();
    bus.iRedirect = 1'b0;
    push_seq(32'h100, 8);
    @(negedge clk);
    vectors++;
    if ({bus.oInstrValid, bus.oMemReq, bus.oMemAddr} !== {1'b0, 1'b1, 32'h100}) begin
      miscompares++;
      $display("FAIL redir_resume got v=%b req=%b addr=%h, required v=0 req=1 addr=00000100",
               bus.oInstrValid, bus.oMemReq, bus.oMemAddr);
    end
    drain(60, used);
    bus.iInstrReady = 1'b0;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL redir_drain got left=%0d, required 0", exp_q.size());
    end
  endtask

  task automatic test_misaligned();
    int used;
    do_reset(1);
    bus.iInstrReady = 1'b1;
    push_seq(32'h0, 3);
    repeat (6) next_cycle();
    bus.iRedirect   = 1'b1;
    bus.iRedirectPC = 32'h102;
    @(negedge clk);
    vectors++;
    if ({bus.oInstrValid, bus.iMemValid, bus.oMisaligned} !== 3'b110 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL mis_setup got v=%b resp=%b mis=%b left=%0d, required v=1 resp=1 mis=0 left=0",
               bus.oInstrValid, bus.iMemValid, bus.oMisaligned, exp_q.size());
    end
    next_cycle();
    bus.iRedirect = 1'b0;
    push_seq(32'h100, 6);
    @(negedge clk);
    vectors++;
    if ({bus.oMisaligned, bus.oInstrValid, bus.oMemReq, bus.oMemAddr} !== {3'b101, 32'h100}) begin
      miscompares++;
      $display("FAIL mis_pulse got mis=%b v=%b req=%b addr=%h, required mis=1 v=0 req=1 addr=00000100",
               bus.oMisaligned, bus.oInstrValid, bus.oMemReq, bus.oMemAddr);
    end
    next_cycle();
    @(negedge clk);
    vectors++;
    if (bus.oMisaligned !== 1'b0) begin
      miscompares++;
      $display("FAIL mis_once got mis=%b, required 0", bus.oMisaligned);
    end
    drain(40, used);
    bus.iInstrReady = 1'b0;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL mis_drain got left=%0d, required 0", exp_q.size());
    end
  endtask

  task automatic test_halt();
    int          reqs;
    int          used;
    logic        found;
    logic [31:0] addr;
    do_reset(2);
    bus.iInstrReady = 1'b1;
    push_seq(32'h0, 5);
    repeat (5) next_cycle();
    bus.iHalt = 1'b1;
    @(negedge clk);
    vectors++;
    if ({bus.oMemReq, bus.oMemAddr} !== {1'b1, 32'h10}) begin
      miscompares++;
      $display("FAIL halt_edge got req=%b addr=%h, required req=1 addr=00000010", bus.oMemReq, bus.oMemAddr);
    end
    next_cycle();
    @(negedge clk);
    vectors++;
    if ({bus.oMemReq, dbg} !== {1'b0, 2'd2}) begin
      miscompares++;
      $display("FAIL halt_stop got req=%b st=%0d, required req=0 st=2", bus.oMemReq, dbg);
    end
    reqs = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.oMemReq) reqs++;
    end
    vectors++;
    if (reqs != 0 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL halt_hold got reqs=%0d left=%0d, required reqs=0 left=0", reqs, exp_q.size());
    end
    next_cycle();
    bus.iHalt = 1'b0;
    push_seq(32'h14, 6);
    first_req(4, found, addr);
    vectors++;
    if (!found || addr !== 32'h14) begin
      miscompares++;
      $display("FAIL halt_resume got found=%b addr=%h, required found=1 addr=00000014", found, addr);
    end
    next_cycle();
    drain(40, used);
    bus.iInstrReady = 1'b0;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL halt_drain got left=%0d, required 0", exp_q.size());
    end
  endtask

  task automatic test_wrap();
    logic [31:0] wexp [3];
    wexp[0] = 32'hFFFF_FFF8;
    wexp[1] = 32'hFFFF_FFFC;
    wexp[2] = 32'h0000_0000;
    do_reset(1);
    @(negedge clk);
    vectors++;
    if (bus2.oMemReq !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_boot got req=%b, required 0", bus2.oMemReq);
    end
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      @(negedge clk);
      vectors++;
      if ({bus2.oMemReq, bus2.oMemAddr} !== {1'b1, wexp[i]}) begin
        miscompares++;
        $display("FAIL wrap_addr%0d got req=%b addr=%h, required req=1 addr=%h",
                 i, bus2.oMemReq, bus2.oMemAddr, wexp[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    int used;
    do_reset(1);
    repeat (3) next_cycle();
    #1;
    vectors++;
    if ({bus.oInstrValid, bus.oMemReq} !== 2'b11) begin
      miscompares++;
      $display("FAIL arst_pre got v=%b req=%b, required v=1 req=1", bus.oInstrValid, bus.oMemReq);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.oInstrValid, bus.oMemReq, bus.oMisaligned, dbg} !== 5'b0) begin
      miscompares++;
      $display("FAIL arst_clear got v=%b req=%b mis=%b st=%0d, required all 0",
               bus.oInstrValid, bus.oMemReq, bus.oMisaligned, dbg);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    bus.iInstrReady = 1'b1;
    push_seq(32'h0, 4);
    drain(30, used);
    bus.iInstrReady = 1'b0;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL arst_restart got left=%0d, required 0", exp_q.size());
    end
  endtask

  initial begin
    rst_n = 1'b0;
    set_idle();
    bus2.iMemValid   = 1'b0;
    bus2.iMemData    = '0;
    bus2.iInstrReady = 1'b0;
    bus2.iRedirect   = 1'b0;
    bus2.iRedirectPC = '0;
    bus2.iHalt       = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_flush();
    test_misaligned();
    test_halt();
    test_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Sequences reads from the instruction memory on behalf of the core front end.
- Generates word-aligned fetch addresses and keeps responses in a small prefetch buffer.
- Presents instructions to decode through a valid/ready handshake.
- Handles branch/jump redirects by flushing buffered and in-flight fetches. Sits between the PC logic and the instruction memory port.

Parameters:
ADDR_WIDTH, 32, width of byte address / PC
DATA_WIDTH, 32, instruction width
RESET_PC, 32'h0000_0000, first fetch address after reset
DEPTH, 4, prefetch buffer entries (power of 2, >=2)

Ports:
iClk  input  1  clock, rising edge
iRstN  input  1  asynchronous active-low reset
oMemReq  output  1  memory read request, one word per cycle when high
oMemAddr  output  ADDR_WIDTH  byte address of request, bits[1:0] always 0
iMemValid  input  1  response valid; responses return in request order, latency >=1 cycle
iMemData  input  DATA_WIDTH  response instruction word
oInstrValid  output  1  buffer head valid
oInstr  output  DATA_WIDTH  instruction at buffer head
oInstrPC  output  ADDR_WIDTH  byte address of oInstr
iInstrReady  input  1  decode accepts head this cycle
iRedirect  input  1  redirect fetch, one-cycle pulse
iRedirectPC  input  ADDR_WIDTH  redirect target
iHalt  input  1  level; stop issuing new requests
oMisaligned  output  1  one-cycle pulse: redirect target had bits[1:0] != 0

Behaviour:
- Reset (async assert, sync release):
  - FSM=BOOT, fetch PC=RESET_PC, buffer empty, outstanding=0, drop=0.
  - All outputs 0.
- FSM states:
  - BOOT: one cycle, no request -> RUN.
  - RUN: issue requests. RUN->HALTED when iHalt=1.
  - HALTED: no new requests; in-flight responses still accepted into the buffer; decode still drains it. HALTED->RUN when iHalt=0.
  - iRedirect is honoured in every state except BOOT, where it is ignored.
- Issue rule (RUN only): oMemReq=1 when occupancy + outstanding < DEPTH.
  - oMemAddr = fetch PC.
  - On issue: fetch PC += 4 (wraps modulo 2^ADDR_WIDTH), outstanding += 1.
  - Each request also pushes its address into a PC tag queue.
- Response:
  - iMemValid with drop=0: write iMemData and its tag PC into the buffer tail; outstanding -= 1.
  - iMemValid with drop>0: discard the response; drop -= 1; outstanding -= 1.
  - The credit rule guarantees the buffer never overflows. A response arriving when the buffer is full is a protocol violation; flag it with an assertion.
- Dequeue: head pops when oInstrValid && iInstrReady. Combinational path from buffer head to oInstr/oInstrPC.
  - Enqueue and dequeue in the same cycle (buffer non-empty) keep occupancy unchanged.
  - When the buffer is empty, an incoming response is not visible until the next cycle. Minimum fetch-to-decode latency = memory latency + 1.
- Redirect (iRedirect=1), takes priority over same-cycle dequeue, enqueue and issue:
  - Buffer cleared; no pop is counted.
  - drop = outstanding, after subtracting a same-cycle response, which is itself discarded.
  - fetch PC = {iRedirectPC[ADDR_WIDTH-1:2],2'b00}. oMisaligned pulses next cycle if iRedirectPC[1:0] != 0.
  - No request is issued in the redirect cycle; issue resumes the next cycle if in RUN.
  - oInstrValid forced 0 in the cycle after the redirect.
  - A back-to-back redirect accumulates drop correctly; drop never exceeds DEPTH.
- Counters:
  - occupancy 0..DEPTH.
  - outstanding 0..DEPTH.
  - Buffer pointers are log2(DEPTH)+1 bits with wrap bit; full/empty detected by pointer compare.
- Reset mid-operation: everything returns to reset values immediately. Stale memory responses after release are not guaranteed to be dropped; the memory is reset together with this block.

Test Plan:
- Reset release, 1-cycle memory, iInstrReady=1: first request at RESET_PC on cycle 2. oInstr/oInstrPC stream 0x0,0x4,0x8,... with one instruction per cycle sustained.
- iInstrReady=0 with 1-cycle memory: exactly 4 requests issued (0x0–0xC), then oMemReq=0. Ready raised: the 4 words drain in order, then fetching resumes at 0x10.
- 3-cycle memory latency, redirect to 0x100 with 2 requests outstanding: both stale responses discarded. Next oInstrPC=0x100 and no stale PC ever appears on the decode port.
- Redirect to 0x102: oMisaligned pulses once, fetch resumes at 0x100. Redirect with simultaneous pop and response: buffer empty next cycle, response dropped.
- iHalt asserted mid-stream: oMemReq drops the next cycle, in-flight responses are still delivered and drained. Deassert: requests resume at the next sequential address.
- RESET_PC=32'hFFFF_FFF8: addresses FFFF_FFF8, FFFF_FFFC, 0000_0000. Async iRstN pulse mid-stream clears oInstrValid and oMemReq immediately without waiting for a clock.
